// File: rtl/tx_block_framer_pkg.sv
// ============================================================================
// tx_block_framer_pkg : PIPE link-rate encoding shared by tx_block_framer
// Revision: 1.0
// ============================================================================
`default_nettype none

package tx_block_framer_pkg;
  typedef enum logic [2:0] {
    GEN1 = 3'd0,
    GEN2 = 3'd1,
    GEN3 = 3'd2,
    GEN4 = 3'd3,
    GEN5 = 3'd4
  } rate_speed_e;
endpackage

`default_nettype wire

// File: rtl/tx_block_framer.sv
// ============================================================================
// tx_block_framer : PIPE TX framer - 128b/130b block tracking, sync headers,
//                   TxDataValid stalls; registered 8b/10b pass-through.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tx_block_framer
  import tx_block_framer_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_NUM_LANES = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              phy_link_up_i,
  input  rate_speed_e                       curr_data_rate_i,
  input  logic [5:0]                        pipe_width_i,
  input  logic [5:0]                        num_active_lanes_i,
  input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_i,
  input  logic [4*MAX_NUM_LANES-1:0]        data_k_i,
  input  logic                              block_type_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_o,
  output logic [MAX_NUM_LANES-1:0]          data_valid_o,
  output logic [4*MAX_NUM_LANES-1:0]        data_k_o,
  output logic [2*MAX_NUM_LANES-1:0]        sync_header_o,
  output logic [MAX_NUM_LANES-1:0]          start_block_o
);

  localparam int LW = MAX_NUM_LANES * DATA_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLOCK = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [3:0]                 beat_cnt_q, beat_cnt_d;
  logic [3:0]                 block_cnt_q, block_cnt_d;
  logic [LW-1:0]              data_q, data_d;
  logic [MAX_NUM_LANES-1:0]   valid_q, valid_d;
  logic [MAX_NUM_LANES-1:0]   start_q, start_d;
  logic [4*MAX_NUM_LANES-1:0] k_q, k_d;
  logic [2*MAX_NUM_LANES-1:0] sh_q, sh_d;
  logic [14:0]                cfg_q;
  logic                       cfg_vld_q;

  logic [14:0]                cfg_w;
  logic                       cfg_change, link_ok, is_128b, accept;
  logic                       first_beat, last_beat, last_block;
  logic [3:0]                 bpb_m1, bps_m1;
  logic [MAX_NUM_LANES-1:0]   lane_mask;
  logic [LW-1:0]              data_mask;
  logic [4*MAX_NUM_LANES-1:0] k_mask;
  logic [2*MAX_NUM_LANES-1:0] sh_first;

  generate
    for (genvar i = 0; i < MAX_NUM_LANES; i++) begin : g_lane
      assign lane_mask[i] = (num_active_lanes_i > 6'(i));
      assign data_mask[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{lane_mask[i]}};
      assign k_mask[4*i +: 4] = {4{lane_mask[i]}};
      assign sh_first[2*i +: 2] = lane_mask[i] ? (block_type_i ? 2'b01 : 2'b10) : 2'b00;
    end
  endgenerate

  // Beats per 16-byte block and blocks per stall, both minus one; unknown widths act as 32.
  always_comb begin
    case (pipe_width_i)
      6'd8:    begin bpb_m1 = 4'd15; bps_m1 = 4'd3;  end
      6'd16:   begin bpb_m1 = 4'd7;  bps_m1 = 4'd7;  end
      default: begin bpb_m1 = 4'd3;  bps_m1 = 4'd15; end
    endcase
  end

  assign cfg_w      = {curr_data_rate_i, pipe_width_i, num_active_lanes_i};
  assign cfg_change = cfg_vld_q && (cfg_w != cfg_q);
  assign link_ok    = phy_link_up_i && !cfg_change;
  assign is_128b    = (curr_data_rate_i >= GEN3);
  assign ready_o    = !rst_i && link_ok && (state_q != ST_STALL);
  assign accept     = valid_i && ready_o;
  assign first_beat = (beat_cnt_q == 4'd0);
  assign last_beat  = (beat_cnt_q == bpb_m1);
  assign last_block = (block_cnt_q == bps_m1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!link_ok || !is_128b) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_BLOCK:
          if (accept) state_d = (last_beat && last_block) ? ST_STALL : ST_BLOCK;
        ST_STALL: state_d = ST_BLOCK;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    block_cnt_d = block_cnt_q;
    data_d      = data_q;
    valid_d     = '0;
    k_d         = k_q;
    sh_d        = sh_q;
    start_d     = '0;
    if (!phy_link_up_i) begin
      beat_cnt_d  = '0;
      block_cnt_d = '0;
      data_d      = '0;
      k_d         = '0;
      sh_d        = '0;
    end else if (cfg_change) begin
      // Partial block is dropped; lanes that just went inactive are blanked.
      beat_cnt_d  = '0;
      block_cnt_d = '0;
      data_d      = data_q & data_mask;
      k_d         = k_q & k_mask;
      sh_d        = '0;
    end else if (!is_128b) begin
      beat_cnt_d  = '0;
      block_cnt_d = '0;
      sh_d        = '0;
      if (accept) begin
        data_d  = data_i & data_mask;
        k_d     = data_k_i & k_mask;
        valid_d = lane_mask;
      end
    end else begin
      k_d = '0;
      if (accept) begin
        data_d  = data_i & data_mask;
        valid_d = lane_mask;
        if (first_beat) begin
          start_d = lane_mask;
          sh_d    = sh_first;
        end
        if (last_beat) begin
          beat_cnt_d  = '0;
          block_cnt_d = last_block ? 4'd0 : block_cnt_q + 4'd1;
        end else begin
          beat_cnt_d  = beat_cnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt_q  <= '0;
      block_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= '0;
      k_q         <= '0;
      sh_q        <= '0;
      start_q     <= '0;
      cfg_q       <= '0;
      cfg_vld_q   <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      block_cnt_q <= block_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      k_q         <= k_d;
      sh_q        <= sh_d;
      start_q     <= start_d;
      cfg_q       <= cfg_w;
      cfg_vld_q   <= phy_link_up_i;
    end
  end

  assign data_o        = data_q;
  assign data_valid_o  = valid_q;
  assign data_k_o      = k_q;
  assign sync_header_o = sh_q;
  assign start_block_o = start_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_block_framer.sv
// ============================================================================
// tb_tx_block_framer : directed vector table plus block/stall sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tx_block_framer;
  import tx_block_framer_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          phy_link_up_i = 1'b1;
  rate_speed_e   curr_data_rate_i = GEN1;
  logic [5:0]    pipe_width_i = 6'd8;
  logic [5:0]    num_active_lanes_i = 6'd4;
  logic [127:0]  data_i = '0;
  logic [15:0]   data_k_i = '0;
  logic          block_type_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [127:0]  data_o;
  logic [3:0]    data_valid_o;
  logic [15:0]   data_k_o;
  logic [7:0]    sync_header_o;
  logic [3:0]    start_block_o;

  int errs = 0;
  int checks = 0;
  bit in_block = 1'b0;

  tx_block_framer #(.DATA_WIDTH(32), .MAX_NUM_LANES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .phy_link_up_i(phy_link_up_i),
    .curr_data_rate_i(curr_data_rate_i), .pipe_width_i(pipe_width_i),
    .num_active_lanes_i(num_active_lanes_i), .data_i(data_i), .data_k_i(data_k_i),
    .block_type_i(block_type_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_k_o(data_k_o),
    .sync_header_o(sync_header_o), .start_block_o(start_block_o)
  );

  always #5 clk_i = ~clk_i;

  // Upstream must not bubble inside a 128b/130b block during the sequences.
  always @(posedge clk_i)
    if (!rst_i && in_block) assert (valid_i) else $error("FAIL mid-block bubble on valid_i");

  typedef struct {
    logic         link;
    logic [5:0]   lanes;
    logic [127:0] din;
    logic [15:0]  kin;
    logic         valid;
    logic         rdy;
    logic [127:0] dout;
    logic [3:0]   dv;
    logic [15:0]  kout;
  } vec_t;

  function automatic vec_t mkv(logic link, logic [5:0] lanes, logic [127:0] din,
                               logic [15:0] kin, logic valid, logic rdy,
                               logic [127:0] dout, logic [3:0] dv, logic [15:0] kout);
    vec_t v;
    v.link = link; v.lanes = lanes; v.din = din; v.kin = kin; v.valid = valid;
    v.rdy = rdy; v.dout = dout; v.dv = dv; v.kout = kout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [127:0] dmask(input logic [3:0] m);
    logic [127:0] r;
    for (int l = 0; l < 4; l++) r[l*32 +: 32] = {32{m[l]}};
    return r;
  endfunction

  function automatic logic [7:0] shval(input logic bt, input logic [3:0] m);
    logic [7:0] r;
    for (int l = 0; l < 4; l++) r[2*l +: 2] = m[l] ? (bt ? 2'b01 : 2'b10) : 2'b00;
    return r;
  endfunction

  function automatic logic [127:0] mkdata(input int c);
    logic [127:0] r;
    for (int l = 0; l < 4; l++) r[l*32 +: 32] = {8'(l + 1), 24'(c * 7 + 3)};
    return r;
  endfunction

  function automatic logic [3:0] lmask(input logic [5:0] nl);
    logic [3:0] m;
    for (int l = 0; l < 4; l++) m[l] = (l < int'(nl));
    return m;
  endfunction

  task automatic do_reset(input rate_speed_e r, input logic [5:0] w, input logic [5:0] nl);
    rst_i = 1'b1; phy_link_up_i = 1'b1; curr_data_rate_i = r;
    pipe_width_i = w; num_active_lanes_i = nl;
    valid_i = 1'b0; data_i = '0; data_k_i = '0; block_type_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_dv", data_valid_o, 0);
    chk("rst_k", data_k_o, 0);
    chk("rst_sh", sync_header_o, 0);
    chk("rst_sb", start_block_o, 0);
    rst_i = 1'b0;
  endtask

  // Continuous valid at 128b/130b: period is one stall cycle after bpb*bps accepted beats.
  task automatic run_g3(input logic [5:0] w, input logic [5:0] nl, input bit alt, input int ncyc);
    int bpb, bps, per, pos, blk;
    logic [3:0] m;
    logic bt;
    logic [127:0] dexp;
    logic [7:0] shexp;
    logic [3:0] dvexp, sbexp;
    bpb = 128 / int'(w); bps = int'(w) / 2; per = bpb * bps + 1;
    m = lmask(nl);
    do_reset(GEN3, w, nl);
    dexp = '0; shexp = '0;
    in_block = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      pos = c % per;
      blk = (c / per) * bps + pos / bpb;
      bt = alt ? (blk % 2 == 0) : 1'b0;
      valid_i = 1'b1;
      data_i = mkdata(c);
      data_k_i = 16'hFFFF;
      block_type_i = (pos % bpb == 0) ? bt : ~bt;
      #4;
      chk("g3_ready", ready_o, (pos != per - 1));
      @(posedge clk_i); #1;
      if (pos != per - 1) begin
        dexp = mkdata(c) & dmask(m);
        dvexp = m;
        sbexp = (pos % bpb == 0) ? m : 4'b0;
        if (pos % bpb == 0) shexp = shval(bt, m);
      end else begin
        dvexp = 4'b0;
        sbexp = 4'b0;
      end
      chk("g3_dv", data_valid_o, dvexp);
      chk("g3_sb", start_block_o, sbexp);
      chk("g3_sh", sync_header_o, shexp);
      chk("g3_data", data_o, dexp);
      chk("g3_k", data_k_o, 0);
    end
    in_block = 1'b0;
  endtask

  localparam logic [127:0] D0 = 128'h00000044_00000033_00000022_000000BC;
  localparam logic [127:0] D1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] D0L2 = 128'h00000000_00000000_00000022_000000BC;
  localparam logic [127:0] D1L2 = 128'h00000000_00000000_BBBBBBBB_AAAAAAAA;

  vec_t tbl[8];

  initial begin
    logic [127:0] d;
    tbl[0] = mkv(1, 6'd4, D0, 16'h0001, 1, 1, D0,   4'hF, 16'h0001);
    tbl[1] = mkv(1, 6'd4, D1, 16'h0000, 1, 1, D1,   4'hF, 16'h0000);
    tbl[2] = mkv(1, 6'd4, D0, 16'h0001, 0, 1, D1,   4'h0, 16'h0000);
    tbl[3] = mkv(1, 6'd4, D0, 16'h8001, 1, 1, D0,   4'hF, 16'h8001);
    tbl[4] = mkv(1, 6'd2, D1, 16'h0000, 1, 0, D0L2, 4'h0, 16'h0001);
    tbl[5] = mkv(1, 6'd2, D1, 16'hFFFF, 1, 1, D1L2, 4'h3, 16'h00FF);
    tbl[6] = mkv(0, 6'd2, D1, 16'hFFFF, 1, 0, '0,   4'h0, 16'h0000);
    tbl[7] = mkv(1, 6'd2, D0, 16'h0001, 1, 1, D0L2, 4'h3, 16'h0001);

    // Gen1 8b/10b pass-through, lane-count change and link drop.
    do_reset(GEN1, 6'd8, 6'd4);
    for (int i = 0; i < 8; i++) begin
      phy_link_up_i = tbl[i].link;
      num_active_lanes_i = tbl[i].lanes;
      data_i = tbl[i].din;
      data_k_i = tbl[i].kin;
      valid_i = tbl[i].valid;
      #4;
      chk("tbl_ready", ready_o, tbl[i].rdy);
      @(posedge clk_i); #1;
      chk("tbl_data", data_o, tbl[i].dout);
      chk("tbl_dv", data_valid_o, tbl[i].dv);
      chk("tbl_k", data_k_o, tbl[i].kout);
      chk("tbl_sh", sync_header_o, 0);
      chk("tbl_sb", start_block_o, 0);
    end

    run_g3(6'd8,  6'd1, 1'b0, 140);
    run_g3(6'd32, 6'd4, 1'b0, 140);
    run_g3(6'd16, 6'd4, 1'b1, 140);

    // Gen3 -> Gen2 switch after beat 5 of an 8-beat block, 2 of 4 lanes.
    do_reset(GEN3, 6'd16, 6'd2);
    in_block = 1'b1;
    for (int c = 0; c < 6; c++) begin
      valid_i = 1'b1; data_i = mkdata(c); data_k_i = 16'hFFFF; block_type_i = 1'b0;
      #4;
      chk("sw_ready", ready_o, 1);
      @(posedge clk_i); #1;
      chk("sw_dv", data_valid_o, 4'b0011);
      chk("sw_sb", start_block_o, (c == 0) ? 4'b0011 : 4'b0000);
      chk("sw_sh", sync_header_o, 8'h0A);
      chk("sw_data", data_o, mkdata(c) & dmask(4'b0011));
    end
    in_block = 1'b0;
    curr_data_rate_i = GEN2;
    data_i = mkdata(50);
    #4;
    chk("sw_chg_ready", ready_o, 0);
    @(posedge clk_i); #1;
    chk("sw_chg_dv", data_valid_o, 0);
    chk("sw_chg_sb", start_block_o, 0);
    for (int c = 0; c < 3; c++) begin
      data_i = mkdata(60 + c); data_k_i = 16'hFFFF;
      #4;
      chk("g2_ready", ready_o, 1);
      @(posedge clk_i); #1;
      chk("g2_dv", data_valid_o, 4'b0011);
      chk("g2_sb", start_block_o, 0);
      chk("g2_sh", sync_header_o, 0);
      chk("g2_k", data_k_o, 16'h00FF);
      chk("g2_data", data_o, mkdata(60 + c) & dmask(4'b0011));
    end

    // Asynchronous reset in the middle of a Gen3 block.
    do_reset(GEN3, 6'd32, 6'd4);
    for (int c = 0; c < 2; c++) begin
      valid_i = 1'b1; data_i = mkdata(c); block_type_i = 1'b0;
      @(posedge clk_i); #1;
      chk("ar_sb", start_block_o, (c == 0) ? 4'hF : 4'h0);
    end
    data_i = mkdata(2);
    #2;
    rst_i = 1'b1;
    #1;
    chk("ar_ready", ready_o, 0);
    chk("ar_dv", data_valid_o, 0);
    chk("ar_data", data_o, 0);
    chk("ar_sh", sync_header_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    d = mkdata(9);
    data_i = d; block_type_i = 1'b1; valid_i = 1'b1;
    #4;
    chk("ar_rel_ready", ready_o, 1);
    @(posedge clk_i); #1;
    chk("ar_rel_sb", start_block_o, 4'hF);
    chk("ar_rel_sh", sync_header_o, 8'h55);
    chk("ar_rel_dv", data_valid_o, 4'hF);
    chk("ar_rel_data", data_o, d);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tx_block_framer.md
Name: tx_block_framer

Overview:
- Transmit-side counterpart of the RX block alignment path in pcie_phy_core.
- Sits between the TX lane data mux and the PIPE TX interface.
- At 128b/130b rates it tracks 16-byte block boundaries per lane, drives sync headers and start_block, and inserts the PIPE TxDataValid stall cycles that absorb the 2-bit sync header overhead.
- At 8b/10b rates it is a registered pass-through with K-symbol flags.

Parameters:
DATA_WIDTH, 32, PIPE data bits per lane (maximum pipe width).
MAX_NUM_LANES, 4, number of physical lanes.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous, active-high reset
phy_link_up_i  input  1  low forces framer idle and clears counters
curr_data_rate_i  input  rate_speed_e  gen1/gen2 select 8b/10b; gen3 and above select 128b/130b
pipe_width_i  input  6  active bits per lane per beat: 8, 16 or 32
num_active_lanes_i  input  6  number of active lanes: 1, 2 or 4
data_i  input  MAX_NUM_LANES*DATA_WIDTH  per-lane TX data, LSB-aligned per lane
data_k_i  input  4*MAX_NUM_LANES  per-byte K flags (8b/10b only)
block_type_i  input  1  0 = data block, 1 = ordered-set block; sampled on the first beat of a block
valid_i  input  1  upstream beat valid
ready_o  output  1  beat accepted when valid_i & ready_o
data_o  output  MAX_NUM_LANES*DATA_WIDTH  registered TX data
data_valid_o  output  MAX_NUM_LANES  PIPE TxDataValid per lane
data_k_o  output  4*MAX_NUM_LANES  registered K flags
sync_header_o  output  2*MAX_NUM_LANES  per-lane sync header: 2'b10 data, 2'b01 ordered set
start_block_o  output  MAX_NUM_LANES  PIPE TxStartBlock per lane

Behaviour:
- Reset (async assert, sync release) and phy_link_up_i=0: all outputs 0, ready_o=0, state ST_IDLE, beat_cnt=0, block_cnt=0.
- Latency: an accepted beat appears on the outputs exactly 1 cycle later. Outputs are registered only.
- Derived values:
  - beats_per_block = 128/pipe_width_i (16, 8 or 4).
  - blocks_per_stall = pipe_width_i/2 (4, 8 or 16).
- Lanes at index >= num_active_lanes_i always drive data_valid_o=0, start_block_o=0, sync_header_o=0 and data_o=0.
- 8b/10b mode:
  - ready_o = phy_link_up_i.
  - Each accepted beat registers data and K flags, with data_valid_o = 1 on active lanes.
  - start_block_o=0, sync_header_o=0, no stalls.
- 128b/130b mode FSM:
  - ST_IDLE: ready_o=1. On an accepted beat, go to ST_BLOCK. This beat is the first beat: start_block_o=1 and sync_header_o latched from block_type_i on the output. beat_cnt=1.
  - ST_BLOCK: ready_o=1. Each accepted beat increments beat_cnt.
  - On the beat where beat_cnt == beats_per_block-1:
    - beat_cnt wraps to 0 and block_cnt increments.
    - If block_cnt == blocks_per_stall-1, go to ST_STALL and wrap block_cnt to 0.
    - Otherwise stay in ST_BLOCK; the next accepted beat is a first beat.
  - ST_STALL: exactly one cycle with ready_o=0. The next output cycle has data_valid_o=0 on all lanes, data_o holds its previous value, and start_block_o=0. Then go to ST_BLOCK with beat_cnt=0.
  - sync_header_o holds its value for the whole block and updates only on first beats.
  - K flags are forced to 0 on the output.
- valid_i low in ST_BLOCK: counters hold; the output cycle shows data_valid_o=0 and start_block_o=0. A mid-block bubble is an upstream protocol violation and the bench flags it with an assertion. The framer still stays consistent.
- A change of curr_data_rate_i, pipe_width_i or num_active_lanes_i, or phy_link_up_i falling: clear counters, return to ST_IDLE, and deassert data_valid_o on the next cycle. Any partial block is discarded.
- Reset asserted mid-block: outputs clear immediately (asynchronous). After release, the next accepted beat is a first beat.
- Counter widths: beat_cnt 4 bits, block_cnt 4 bits. No overflow occurs for the legal pipe widths. Illegal pipe widths are treated as 32.

Test Plan:
- Gen1, 4 lanes, width 8, continuous valid_i, data_i=0xBC on lane 0 with K=1 -> 1-cycle latency; data_valid_o=4'b1111; data_k_o[0]=1; sync_header_o=0; start_block_o=0; ready_o never low.
- Gen3, 1 lane, width 8, continuous data blocks -> start_block_o[0] pulses every 16 beats; sync_header_o[1:0]=2'b10; after 4 blocks (64 beats) exactly one cycle of data_valid_o=0 and ready_o=0; the pattern repeats.
- Gen3, 4 lanes, width 32 -> start_block_o=4'b1111 every 4 beats; one stall after 16 blocks (64 beats); lanes get identical timing.
- Gen3, width 16, alternating block_type_i 1/0 -> sync_header_o alternates 2'b01/2'b10 per 8-beat block, constant within each block; stall every 8 blocks.
- Gen3, 2 active of 4 lanes, rate switch to gen2 after beat 5 of a block -> data_valid_o=0 for one cycle; then pass-through with data_valid_o=4'b0011 and start_block_o=0.
- rst_i pulsed asynchronously mid-block at gen3 -> all outputs 0 within the same cycle; after release the first accepted beat has start_block_o=1.
